seg_scan_capture: RTL

Reads a multiplexed, active-low four-digit seven-segment bus (anodes plus cathodes) and reconstructs the hexadecimal value being displayed. It is the receive end of the display path. It samples each digit only after the bus has held still for a programmable number of cycles, maps the cathode pattern back to a nibble, and assembles a 16-bit word. A word is published only once all four digits have been captured. Used for self-check of display drivers and for snooping an external display bus on the board.

---
 rtl/seg_scan_capture.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// Receive end of a multiplexed active-low 4-digit seven-segment bus.
// Optional SEG_SCAN_CAPTURE_DP_EN adds the decimal-point input and value_dp.
module seg_scan_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
`ifdef SEG_SCAN_CAPTURE_DP_EN
    input  logic        dp,
    output logic [3:0]  value_dp,
`endif
    input  logic        clr_err,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_seen,
    output logic [3:0]  pattern_err
);

`ifdef SEG_SCAN_CAPTURE_DP_EN
    localparam int BW = 12;
    logic [BW-1:0] bus_in;
    assign bus_in = {dp, an, seg};
`else
    localparam int BW = 11;
    logic [BW-1:0] bus_in;
    assign bus_in = {an, seg};
`endif

    localparam logic [7:0] STB_LAST = 8'(STABLE_CYCLES - 1);

    logic [BW-1:0] bus_q, bus_p;
    logic [7:0]    cnt;
    logic          stb;
    logic          match;
    logic [3:0]    an_s;
    logic [6:0]    seg_s;
    logic [6:0]    segr;
    logic [3:0]    nib;
    logic          map_ok;
    logic [1:0]    idx;
    logic          sel_ok;
    logic [3:0]    dset, eset;
    logic [15:0]   shadow;
    logic          complete;

    assign match = (bus_q == bus_p);
    assign an_s  = bus_q[10:7];
    assign seg_s = bus_q[6:0];
    // reorder so literals below read a..g left to right
    assign segr  = {seg_s[0], seg_s[1], seg_s[2], seg_s[3],
                    seg_s[4], seg_s[5], seg_s[6]};

    always_comb begin
        map_ok = 1'b1;
        nib    = 4'h0;
        case (segr)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
            default:    map_ok = 1'b0;
        endcase
    end

    always_comb begin
        sel_ok = 1'b1;
        idx    = 2'd0;
        case (an_s)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: sel_ok = 1'b0;
        endcase
    end

    assign dset = (stb && sel_ok && map_ok)  ? (4'b0001 << idx) : 4'b0000;
    assign eset = (stb && sel_ok && !map_ok) ? (4'b0001 << idx) : 4'b0000;
    assign complete = (digit_seen == 4'hF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_q <= '1;
            bus_p <= '1;
            cnt   <= 8'd0;
            stb   <= 1'b0;
        end else begin
            bus_q <= bus_in;
            bus_p <= bus_q;
            // strobe is registered: it is high the cycle cnt sits at the limit
            stb   <= match && (cnt == STB_LAST);
            if (!match)
                cnt <= 8'd1;
            else if (cnt <= STB_LAST)
                cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow      <= 16'h0000;
            value       <= 16'h0000;
            frame_valid <= 1'b0;
            digit_seen  <= 4'h0;
            pattern_err <= 4'h0;
        end else begin
            frame_valid <= complete;
            if (complete)
                value <= shadow;
            digit_seen  <= (complete ? 4'h0 : digit_seen) | dset;
            pattern_err <= (clr_err ? 4'h0 : pattern_err) | eset;
            if (|dset)
                shadow[{idx, 2'b00} +: 4] <= nib;
        end
    end

`ifdef SEG_SCAN_CAPTURE_DP_EN
    logic [3:0] shadow_dp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_dp <= 4'h0;
            value_dp  <= 4'h0;
        end else begin
            if (complete)
                value_dp <= shadow_dp;
            if (|dset)
                shadow_dp[idx] <= ~bus_q[11];
        end
    end
`endif

endmodule
